// File: rtl/qram_access_sequencer.sv
// qram_access_sequencer: command stage in front of the QRAM-in-SDRAM cell pair.
// Takes one host request at a time, shifts the address out MSB first on
// AddressQBit, presents write data, pulses Read or Write for a fixed window,
// captures the cell output and returns a response.
//
// Handshakes: a transfer happens on a rising DDRClockP edge where valid and
// ready are both high. The sender holds valid and its payload until then. The
// receiver may raise ready freely. ReqReady is high only in IDLE. RspValid is
// high only in RESP, and RspData/RspWasWrite/RspError are held stable while it
// is high.
//
// Optional build macro QRAM_WRITE_VERIFY_EN: after every write the cell is read
// back. A SETUP_CYCLES gap precedes HOLD_CYCLES of Read, and a mismatch between
// the sample and the written data is reported on RspError.
module qram_access_sequencer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                  DDRClockP,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic                  ReqData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic                  RspData,
  output logic                  RspWasWrite,
  output logic                  RspError,
  output logic                  AddressQBit,
  output logic                  inputQBit,
  output logic                  Read,
  output logic                  Write,
  input  logic                  outputQBit,
  output logic [2:0]            dbg_state_o
);

  localparam int MAX_AS = (ADDR_WIDTH > SETUP_CYCLES) ? ADDR_WIDTH : SETUP_CYCLES;
  localparam int MAX_C  = (MAX_AS > HOLD_CYCLES) ? MAX_AS : HOLD_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] ADDR_LOAD  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
`ifdef QRAM_WRITE_VERIFY_EN
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_RBACK  = 3'd6;
`endif

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  data_q;
  logic                  rsp_data_q;
  logic                  cnt_zero;
  logic                  addr_bit;
  logic                  lines_on;
  logic                  in_resp;

  assign cnt_zero = (cnt_q == '0);

  // Phase sequencing: each phase loads its length minus one and ends at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          state_d = S_ADDR;
          cnt_d   = ADDR_LOAD;
        end
      end
      S_ADDR: begin
        if (cnt_zero) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_ACCESS;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACCESS: begin
        if (cnt_zero) begin
`ifdef QRAM_WRITE_VERIFY_EN
          if (write_q) begin
            state_d = S_GAP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = S_RESP;
          end
`else
          state_d = S_RESP;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef QRAM_WRITE_VERIFY_EN
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_RBACK;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RBACK: begin
        if (cnt_zero) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      S_RESP: begin
        if (RspReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; reset abandons any request in flight.
  always_ff @(posedge DDRClockP or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch at acceptance and response capture at the last strobe edge.
  always_ff @(posedge DDRClockP or posedge Reset) begin
    if (Reset) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= 1'b0;
      rsp_data_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && ReqValid) begin
        write_q <= ReqWrite;
        addr_q  <= ReqAddress;
        data_q  <= ReqData;
      end
      if (state_q == S_ACCESS && cnt_zero) begin
        rsp_data_q <= write_q ? data_q : outputQBit;
      end
    end
  end

`ifdef QRAM_WRITE_VERIFY_EN
  logic rsp_err_q;

  // Readback compare: a write is flagged when the cell returns other data.
  always_ff @(posedge DDRClockP or posedge Reset) begin
    if (Reset) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == S_ACCESS && cnt_zero) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == S_RBACK && cnt_zero) begin
      rsp_err_q <= (outputQBit != data_q);
    end
  end

  assign lines_on = (state_q == S_SETUP) || (state_q == S_ACCESS) ||
                    (state_q == S_GAP) || (state_q == S_RBACK);
  assign Read     = ((state_q == S_ACCESS) && !write_q) || (state_q == S_RBACK);
  assign RspError = in_resp & rsp_err_q;
`else
  assign lines_on = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign Read     = (state_q == S_ACCESS) && !write_q;
  assign RspError = 1'b0;
`endif

  // Cell pins and response outputs decode directly from registered state,
  // so an asynchronous reset clears them immediately.
  assign addr_bit    = |(addr_q & (ADDR_WIDTH'(1) << cnt_q));
  assign in_resp     = (state_q == S_RESP);
  assign AddressQBit = (state_q == S_ADDR) ? addr_bit : (lines_on & addr_q[0]);
  assign inputQBit   = lines_on & write_q & data_q;
  assign Write       = (state_q == S_ACCESS) && write_q;
  assign ReqReady    = (state_q == S_IDLE) && !Reset;
  assign RspValid    = in_resp;
  assign RspData     = in_resp & rsp_data_q;
  assign RspWasWrite = in_resp & write_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qram_access_sequencer.sv
// Directed bench for qram_access_sequencer at default parameters.
// Also follows the QRAM_WRITE_VERIFY_EN build when that macro is defined.
module tb_qram_access_sequencer;

  localparam int AW = 4;
  localparam int SC = 1;
  localparam int HC = 2;
`ifdef QRAM_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_data;
  logic [AW-1:0] req_addr;
  logic          rsp_valid, rsp_ready, rsp_data, rsp_was_write, rsp_error;
  logic          addr_qbit, input_qbit, rd, wr, output_qbit;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  qram_access_sequencer #(.ADDR_WIDTH(AW), .SETUP_CYCLES(SC), .HOLD_CYCLES(HC)) dut (
    .DDRClockP  (clk),
    .Reset      (rst),
    .ReqValid   (req_valid),
    .ReqReady   (req_ready),
    .ReqWrite   (req_write),
    .ReqAddress (req_addr),
    .ReqData    (req_data),
    .RspValid   (rsp_valid),
    .RspReady   (rsp_ready),
    .RspData    (rsp_data),
    .RspWasWrite(rsp_was_write),
    .RspError   (rsp_error),
    .AddressQBit(addr_qbit),
    .inputQBit  (input_qbit),
    .Read       (rd),
    .Write      (wr),
    .outputQBit (output_qbit),
    .dbg_state_o(dbg_state)
  );

  // Clock: rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic          data;
    logic          outq;
    int            stall;
    logic          exp_data;
    logic          exp_ww;
    logic          exp_err_v;
  } vec_t;

  vec_t vecs[7];

  // Pin order: ReqReady RspValid RspData RspWasWrite RspError AddressQBit inputQBit Read Write
  function automatic logic [8:0] pins();
    return {req_ready, rsp_valid, rsp_data, rsp_was_write, rsp_error,
            addr_qbit, input_qbit, rd, wr};
  endfunction

  task automatic check_pins(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = pins();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: pins got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat(input vec_t v);
    return AW + SC + HC + 1 + ((VERIFY && v.wr) ? (SC + HC) : 0);
  endfunction

  // Expected pins in cycle c after acceptance (acceptance edge is edge 0).
  function automatic logic [8:0] exp_pins(input vec_t v, input int c);
    logic a, d, r, w, e;
    int   acc_lo, acc_hi, rb_lo, rb_hi;
    e = VERIFY ? v.exp_err_v : 1'b0;
    if (c == lat(v)) return {1'b0, 1'b1, v.exp_data, v.exp_ww, e, 4'b0000};
    a = 1'b0; d = 1'b0; r = 1'b0; w = 1'b0;
    acc_lo = AW + SC + 1;
    acc_hi = AW + SC + HC;
    rb_lo  = acc_hi + SC + 1;
    rb_hi  = acc_hi + SC + HC;
    if (c <= AW) begin
      a = v.addr[AW-c];
    end else begin
      a = v.addr[0];
      d = v.wr & v.data;
      if (c >= acc_lo && c <= acc_hi) begin
        w = v.wr;
        r = ~v.wr;
      end
      if (VERIFY && v.wr && c >= rb_lo && c <= rb_hi) r = 1'b1;
    end
    return {2'b00, 3'b000, a, d, r, w};
  endfunction

  // Driver: one full transaction with per-cycle pin checks and an optional
  // response stall. outputQBit carries the wanted value only in the cycle
  // ending at the capture edge, so a mistimed capture reads the complement.
  task automatic run_vec(input vec_t v, input string tag);
    int L;
    L = lat(v);
    @(negedge clk);
    check_pins({tag, "_idle"}, 9'b1_0000_0000);
    req_valid   = 1'b1;
    req_write   = v.wr;
    req_addr    = v.addr;
    req_data    = v.data;
    output_qbit = ~v.outq;
    rsp_ready   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_data  = ~v.data;
    for (int c = 1; c <= L; c++) begin
      if (c > 1) @(negedge clk);
      check_pins($sformatf("%s_c%0d", tag, c), exp_pins(v, c));
      output_qbit = (c == L - 1) ? v.outq : ~v.outq;
    end
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check_pins($sformatf("%s_stall%0d", tag, s), exp_pins(v, L));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_pins({tag, "_back_idle"}, 9'b1_0000_0000);
  endtask

  initial begin
    vec_t rv;
    int   accepts[$];
    int   overlap;

    // Clock/reset block
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_data = 1'b0; rsp_ready = 1'b0; output_qbit = 1'b0;
    #2;
    check_pins("reset_state", 9'b0_0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //           wr    addr     data  outq  stall exp_d exp_ww exp_err(verify)
    vecs[0] = '{1'b1, 4'b1010, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'b0011, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'b0101, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'b0110, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'b1111, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'b0001, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 4'b1000, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset pulsed in ACCESS cycle 6 of a read
    rv = '{1'b0, 4'b0011, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = rv.addr; output_qbit = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 2; c <= 6; c++) @(negedge clk);
    check_pins("rst_pre_access", exp_pins(rv, 6));
    #1 rst = 1'b1;
    #1 check_pins("rst_mid_drop", 9'b0_0000_0000);
    @(negedge clk);
    check_pins("rst_held", 9'b0_0000_0000);
    rst = 1'b0;
    @(negedge clk);
    check_pins("rst_after_release", 9'b1_0000_0000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_pins($sformatf("rst_no_rsp%0d", c), 9'b1_0000_0000);
    end

    // ReqValid held high with reads, RspReady always high
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'b1001; rsp_ready = 1'b1;
    overlap = 0;
    for (int c = 0; c < 40; c++) begin
      if (req_valid && req_ready) accepts.push_back(c);
      if (rd && wr) overlap++;
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check_int("stream_no_overlap", overlap, 0);
    check_int("stream_accept_count", accepts.size(), 5);
    for (int i = 1; i < accepts.size(); i++)
      check_int($sformatf("stream_spacing%0d", i), accepts[i] - accepts[i-1], AW + SC + HC + 2);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
